// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB bus between N_REQ requesters and bounds ACCESS with a ready-timeout.
// Latency: request seen -> done in 4 cycles minimum (IDLE, SETUP, ACCESS, COMPLETE); back-to-back spacing 5 cycles.
// Backpressure: req is a level that is held until done; a slow slave stalls ACCESS until apb_ready or the timeout.
module apb_master_arbiter #(
    parameter int N_REQ   = 2,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_write,
    input  logic [2*N_REQ-1:0]   req_slave,
    input  logic [AW*N_REQ-1:0]  req_addr,
    input  logic [DW*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [DW-1:0]        rdata_out,
    output logic [1:0]           apb_sel,
    output logic                 apb_enable,
    output logic                 apb_write,
    output logic [AW-1:0]        apb_addr,
    output logic [DW-1:0]        apb_wdata,
    input  logic                 apb_ready,
    input  logic [DW-1:0]        apb_rdata
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        COMPLETE = 3'd3,
        ERR_DONE = 3'd4,
        RECOVER  = 3'd5
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_q;
    logic [7:0]      cnt;

    logic [IW-1:0]   win;
    logic            win_write;
    logic [1:0]      win_slave;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            found;
    int              j;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = N_REQ'(1) << idx;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        next_ptr = (int'(w) == N_REQ - 1) ? '0 : w + IW'(1);
    endfunction

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
        win_write = req_write[int'(win)];
        win_slave = req_slave[2*int'(win) +: 2];
        win_addr  = req_addr[AW*int'(win) +: AW];
        win_wdata = req_wdata[DW*int'(win) +: DW];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            win_q      <= '0;
            cnt        <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata_out  <= '0;
            apb_sel    <= 2'd0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= '0;
            apb_wdata  <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= onehot(win);
                        win_q <= win;
                        if (win_slave == 2'd0) begin
                            state <= ERR_DONE;
                            done  <= onehot(win);
                            err   <= 1'b1;
                            ptr   <= next_ptr(win);
                        end else begin
                            state     <= SETUP;
                            apb_sel   <= win_slave;
                            apb_write <= win_write;
                            apb_addr  <= win_addr;
                            apb_wdata <= win_wdata;
                        end
                    end
                end
                SETUP: begin
                    cnt        <= 8'(TIMEOUT);
                    apb_enable <= 1'b1;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (apb_ready) begin
                        state <= COMPLETE;
                        done  <= onehot(win_q);
                        ptr   <= next_ptr(win_q);
                        if (!apb_write) rdata_out <= apb_rdata;
                        apb_sel    <= 2'd0;
                        apb_enable <= 1'b0;
                        apb_write  <= 1'b0;
                        apb_addr   <= '0;
                        apb_wdata  <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state      <= ERR_DONE;
                            done       <= onehot(win_q);
                            err        <= 1'b1;
                            ptr        <= next_ptr(win_q);
                            apb_sel    <= 2'd0;
                            apb_enable <= 1'b0;
                            apb_write  <= 1'b0;
                            apb_addr   <= '0;
                            apb_wdata  <= '0;
                        end
                    end
                end
                COMPLETE, ERR_DONE: begin
                    gnt   <= '0;
                    state <= RECOVER;
                end
                RECOVER: begin
                    // Wait for the slave's registered ready to fall before arbitrating again.
                    if (!apb_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: queued expectations are checked by a done-driven monitor.
module tb_apb_master_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [3:0]  req_slave;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [7:0]  rdata_out;
    logic [1:0]  apb_sel;
    logic        apb_enable;
    logic        apb_write;
    logic [7:0]  apb_addr;
    logic [7:0]  apb_wdata;
    logic        apb_ready;
    logic [7:0]  apb_rdata;

    apb_master_arbiter #(.N_REQ(2), .AW(8), .DW(8), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write),
        .req_slave(req_slave), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata_out(rdata_out),
        .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    typedef struct {
        int         idx;
        bit         err;
        logic [7:0] rdata;
        int         acc;
        logic [1:0] sel;
        logic [7:0] addr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   wait_n = 1;
    int   acnt = 0;
    int   acc = 0;
    logic [1:0] seen_sel = 2'd0;
    logic [7:0] seen_addr = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Slave model: ready rises on the wait_n-th ACCESS cycle; wait_n==0 never answers.
    always @(negedge clk) begin
        if (apb_sel != 2'd0 && apb_enable) begin
            acnt++;
            apb_ready = (wait_n != 0) && (acnt >= wait_n);
        end else begin
            acnt = 0;
            apb_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("gnt_onehot", 32'($countones(gnt) > 1), 32'd0);
        if (gnt == 2'b00 && done == 2'b00) begin
            acc = 0;
            seen_sel = 2'd0;
            seen_addr = 8'd0;
        end else begin
            if (apb_sel != 2'd0 && !apb_enable) begin
                seen_sel = apb_sel;
                seen_addr = apb_addr;
            end
            if (apb_enable) acc++;
        end
        if (done != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_vec", 32'(done), 32'(2'b01 << e.idx));
                chk("done_err", 32'(err), 32'(e.err));
                chk("done_rdata", 32'(rdata_out), 32'(e.rdata));
                chk("access_cycles", 32'(acc), 32'(e.acc));
                chk("setup_sel", 32'(seen_sel), 32'(e.sel));
                chk("setup_addr", 32'(seen_addr), 32'(e.addr));
                chk("sel_at_done", 32'(apb_sel), 32'd0);
            end
            done_cnt++;
            acc = 0;
            seen_sel = 2'd0;
            seen_addr = 8'd0;
        end
    end

    task automatic set_req(input int i, input bit w, input logic [1:0] s,
                           input logic [7:0] a, input logic [7:0] d);
        req_write[i]      = w;
        req_slave[2*i +: 2] = s;
        req_addr[8*i +: 8]  = a;
        req_wdata[8*i +: 8] = d;
    endtask

    task automatic push(input int idx, input bit e, input logic [7:0] rd,
                        input int ac, input logic [1:0] s, input logic [7:0] a);
        exp_t x;
        x.idx = idx; x.err = e; x.rdata = rd; x.acc = ac; x.sel = s; x.addr = a;
        q.push_back(x);
        exp_done++;
    endtask

    task automatic wait_all(input string name);
        int n;
        n = 0;
        while (done_cnt < exp_done && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < exp_done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d dones expected %0d", name, done_cnt, exp_done);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata_out), 32'd0);
        chk({tag, "_sel"}, 32'(apb_sel), 32'd0);
        chk({tag, "_enable"}, 32'(apb_enable), 32'd0);
        chk({tag, "_write"}, 32'(apb_write), 32'd0);
        chk({tag, "_addr"}, 32'(apb_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(apb_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; req = '0; req_write = '0; req_slave = '0;
        req_addr = '0; req_wdata = '0; apb_ready = 1'b0; apb_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, ready on the 2nd ACCESS cycle.
        wait_n = 2; apb_rdata = 8'hFF;
        set_req(0, 1'b1, 2'd1, 8'h10, 8'hA5);
        push(0, 1'b0, 8'h00, 2, 2'd1, 8'h10);
        req[0] = 1'b1;
        @(negedge clk);
        chk("setup_gnt", 32'(gnt), 32'h1);
        chk("setup_sel1", 32'(apb_sel), 32'h1);
        chk("setup_enable", 32'(apb_enable), 32'h0);
        chk("setup_write", 32'(apb_write), 32'h1);
        chk("setup_wdata", 32'(apb_wdata), 32'hA5);
        wait_all("write");
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Single read.
        wait_n = 1; apb_rdata = 8'h3C;
        set_req(1, 1'b0, 2'd2, 8'h22, 8'h00);
        push(1, 1'b0, 8'h3C, 1, 2'd2, 8'h22);
        req[1] = 1'b1;
        wait_all("read");
        req[1] = 1'b0;
        apb_rdata = 8'h99;
        repeat (10) @(negedge clk);
        chk("rdata_held", 32'(rdata_out), 32'h3C);

        // Contention with ptr at 0: 0,1,0,1.
        set_req(0, 1'b1, 2'd1, 8'h40, 8'h11);
        set_req(1, 1'b1, 2'd2, 8'h50, 8'h22);
        push(0, 1'b0, 8'h3C, 1, 2'd1, 8'h40);
        push(1, 1'b0, 8'h3C, 1, 2'd2, 8'h50);
        push(0, 1'b0, 8'h3C, 1, 2'd1, 8'h40);
        push(1, 1'b0, 8'h3C, 1, 2'd2, 8'h50);
        req = 2'b11;
        wait_all("contention");
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Timeout on a read; req dropped mid-transfer must not abort it.
        wait_n = 0; apb_rdata = 8'hEE;
        set_req(0, 1'b0, 2'd3, 8'h33, 8'h00);
        push(0, 1'b1, 8'h3C, 4, 2'd3, 8'h33);
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        req[0] = 1'b0;
        wait_all("timeout");
        repeat (3) @(negedge clk);

        // Illegal slave id: error done one edge after the request is sampled.
        set_req(1, 1'b1, 2'd0, 8'h44, 8'h55);
        push(1, 1'b1, 8'h3C, 0, 2'd0, 8'h00);
        req[1] = 1'b1;
        @(negedge clk);
        chk("illegal_done", 32'(done), 32'h2);
        chk("illegal_err", 32'(err), 32'h1);
        chk("illegal_sel", 32'(apb_sel), 32'h0);
        wait_all("illegal");
        req[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during ACCESS aborts without done.
        wait_n = 0;
        set_req(0, 1'b1, 2'd1, 8'h66, 8'h77);
        req[0] = 1'b1;
        n = 0;
        while (!apb_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_access", 32'(apb_enable), 32'h1);
        reset = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b1;
        repeat (4) @(negedge clk);
        wait_n = 1; apb_rdata = 8'h5A;
        set_req(1, 1'b0, 2'd3, 8'h12, 8'h00);
        push(1, 1'b0, 8'h5A, 1, 2'd3, 8'h12);
        req[1] = 1'b1;
        @(negedge clk);
        chk("post_reset_gnt", 32'(gnt), 32'h2);
        wait_all("post_reset");
        req[1] = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
